// File: rtl/vx_barrier_unit.sv
// Per-core warp barrier tracker: records arrivals per barrier slot, holds
// arrived warps stalled, and pulses a release mask when the last warp arrives.
module vx_barrier_unit #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned NW_BITS      = $clog2(NUM_WARPS),
  parameter int unsigned NB_BITS      = $clog2(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    barrier_valid,
  input  logic [NW_BITS-1:0]      barrier_wid,
  input  logic [NB_BITS-1:0]      barrier_id,
  input  logic [NW_BITS-1:0]      barrier_size_m1,
  input  logic                    clear_valid,
  input  logic [NW_BITS-1:0]      clear_wid,
  output logic [NUM_WARPS-1:0]    stalled_wmask,
  output logic                    release_valid,
  output logic [NUM_WARPS-1:0]    release_wmask,
  output logic [NUM_BARRIERS-1:0] barrier_busy
);

  localparam int unsigned CW = NW_BITS + 1;

  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] mask_q, mask_d;
  logic [NUM_BARRIERS-1:0][CW-1:0]        count_q, count_d;
  logic [NUM_BARRIERS-1:0][NW_BITS-1:0]   size_q, size_d;
  logic [NUM_WARPS-1:0]                   stalled_q, stalled_d;
  logic                                   rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0]                   rel_wmask_q, rel_wmask_d;
  logic [NUM_BARRIERS-1:0]                busy_q, busy_d;

  logic [NUM_WARPS-1:0] wbit_c;
  logic [NUM_WARPS-1:0] cbit_c;
  logic                 arrive_ok_c;
  logic [NW_BITS-1:0]   eff_size_c;

  assign wbit_c = NUM_WARPS'(1) << barrier_wid;
  assign cbit_c = NUM_WARPS'(1) << clear_wid;

  // A warp already parked on any slot cannot arrive again; a same-warp clear wins.
  assign arrive_ok_c = barrier_valid
                     && !(clear_valid && (clear_wid == barrier_wid))
                     && ((stalled_q & wbit_c) == '0);

  always_comb begin
    mask_d      = mask_q;
    count_d     = count_q;
    size_d      = size_q;
    rel_valid_d = 1'b0;
    rel_wmask_d = '0;
    eff_size_c  = '0;
    stalled_d   = '0;
    busy_d      = '0;

    if (clear_valid) begin
      for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
        if ((mask_q[b] & cbit_c) != '0) begin
          mask_d[b]  = mask_q[b] & ~cbit_c;
          count_d[b] = count_q[b] - CW'(1);
        end
      end
    end

    // Release check runs on the post-clear count.
    if (arrive_ok_c) begin
      if (count_d[barrier_id] == '0) begin
        eff_size_c             = barrier_size_m1;
        size_d[barrier_id]     = barrier_size_m1;
      end else begin
        eff_size_c             = size_q[barrier_id];
      end
      if (count_d[barrier_id] == CW'(eff_size_c)) begin
        rel_valid_d            = 1'b1;
        rel_wmask_d            = mask_d[barrier_id] | wbit_c;
        mask_d[barrier_id]     = '0;
        count_d[barrier_id]    = '0;
      end else begin
        mask_d[barrier_id]     = mask_d[barrier_id] | wbit_c;
        count_d[barrier_id]    = count_d[barrier_id] + CW'(1);
      end
    end

    for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
      stalled_d = stalled_d | mask_d[b];
      busy_d[b] = (count_d[b] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q      <= '0;
      count_q     <= '0;
      size_q      <= '0;
      stalled_q   <= '0;
      rel_valid_q <= 1'b0;
      rel_wmask_q <= '0;
      busy_q      <= '0;
    end else begin
      mask_q      <= mask_d;
      count_q     <= count_d;
      size_q      <= size_d;
      stalled_q   <= stalled_d;
      rel_valid_q <= rel_valid_d;
      rel_wmask_q <= rel_wmask_d;
      busy_q      <= busy_d;
    end
  end

  assign stalled_wmask = stalled_q;
  assign release_valid = rel_valid_q;
  assign release_wmask = rel_wmask_q;
  assign barrier_busy  = busy_q;

endmodule
